// File: rtl/led_cube_pkg.sv
// Shared types and constants for the 8x8x8 LED cube animation path.
package led_cube_pkg;

  localparam int unsigned CUBE_DIM    = 8;
  localparam int unsigned FRAME_BYTES = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHOW    = 3'd2,
    PAUSED  = 3'd3,
    ADVANCE = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    LOOP     = 2'd0,
    ONCE     = 2'd1,
    PINGPONG = 2'd2
  } seq_mode_e;

endpackage

// File: rtl/led_cube_frame_timer.sv
// Saturating frame-period counter; load samples a new period and restarts from 0.
module led_cube_frame_timer #(
  parameter int unsigned TICK_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              en,
  input  logic [TICK_W-1:0] period,
  output logic              expired_c
);

  logic [TICK_W-1:0] count_q;
  logic [TICK_W-1:0] period_q;

  assign expired_c = (count_q == period_q - TICK_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      period_q <= TICK_W'(1);
    end else if (load) begin
      count_q  <= '0;
      period_q <= period;
    end else if (clear) begin
      count_q  <= '0;
    end else if (en && !expired_c) begin
      count_q  <= count_q + TICK_W'(1);
    end
  end

endmodule

// File: rtl/led_cube_anim_sequencer.sv
// Animation sequencer: steps frames of the selected animation and handshakes the frame driver.
// Optional build macro LED_SEQ_AUTOCYCLE_EN: LOOP wrap advances to the next animation.
module led_cube_anim_sequencer
  import led_cube_pkg::*;
#(
  parameter  int unsigned NUM_ANIM    = 5,
  parameter  int unsigned FRAMES      = 150,
  parameter  int unsigned FRAME_TICKS = 1500000,
  parameter  int unsigned TICK_W      = 21,
  localparam int unsigned ANIM_W      = (NUM_ANIM > 1) ? $clog2(NUM_ANIM) : 1,
  localparam int unsigned FRAME_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               step,
  input  logic [1:0]         mode,
  input  logic [ANIM_W-1:0]  anim_req,
  input  logic [TICK_W-1:0]  speed_ticks,
  input  logic               frame_done,
  output logic               frame_start,
  output logic               frame_stop,
  output logic [ANIM_W-1:0]  anim_sel,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               busy,
  output logic               seq_done,
  output logic [2:0]         state_dbg
);

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);

  seq_state_e         state_q, state_d;
  logic               ret_pause_q, ret_pause_d;
  logic [ANIM_W-1:0]  anim_sel_q, anim_sel_d;
  logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;
  logic               dir_q, dir_d;
  logic               done_seen_q, done_seen_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_stop_q, frame_stop_d;
  logic               seq_done_q, seq_done_d;
  logic               busy_q;

  seq_mode_e          mode_c;
  logic [TICK_W-1:0]  period_c;
  logic               last_c, first_c, anim_switch_c;
  logic               tmr_clear_c, tmr_load_c, tmr_en_c, tmr_expired_c;

  assign mode_c   = (mode == 2'd3) ? LOOP : seq_mode_e'(mode);
  assign period_c = (speed_ticks == '0) ? TICK_W'(FRAME_TICKS) : speed_ticks;
  assign last_c   = (frame_idx_q == LAST_FRAME);
  assign first_c  = (frame_idx_q == '0);

  led_cube_frame_timer #(.TICK_W(TICK_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmr_clear_c),
    .load     (tmr_load_c),
    .en       (tmr_en_c),
    .period   (period_c),
    .expired_c(tmr_expired_c)
  );

  // Next-state, next-frame and pulse generation
  always_comb begin
    state_d       = state_q;
    ret_pause_d   = ret_pause_q;
    anim_sel_d    = anim_sel_q;
    frame_idx_d   = frame_idx_q;
    dir_d         = dir_q;
    done_seen_d   = done_seen_q;
    frame_start_d = 1'b0;
    frame_stop_d  = 1'b0;
    seq_done_d    = 1'b0;
    tmr_clear_c   = 1'b0;
    tmr_load_c    = 1'b0;
    tmr_en_c      = 1'b0;
`ifdef LED_SEQ_AUTOCYCLE_EN
    anim_switch_c = 1'b0;
`else
    anim_switch_c = (anim_req != anim_sel_q);
`endif

    if (stop && (state_q != IDLE)) begin
      state_d      = IDLE;
      frame_stop_d = 1'b1;
      frame_idx_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmr_clear_c = 1'b1;
          if (start && !stop) state_d = LOAD;
        end
        LOAD: begin
          anim_sel_d    = anim_req;
          frame_idx_d   = '0;
          dir_d         = 1'b0;
          done_seen_d   = 1'b0;
          ret_pause_d   = 1'b0;
          tmr_load_c    = 1'b1;
          frame_start_d = 1'b1;
          state_d       = SHOW;
        end
        SHOW: begin
          tmr_en_c = 1'b1;
          if (frame_done) done_seen_d = 1'b1;
          if (pause) begin
            state_d = PAUSED;
          end else if (tmr_expired_c && done_seen_q) begin
            state_d     = ADVANCE;
            ret_pause_d = 1'b0;
          end
        end
        PAUSED: begin
          if (frame_done) done_seen_d = 1'b1;
          if (!pause) begin
            state_d = SHOW;
          end else if (step) begin
            state_d     = ADVANCE;
            ret_pause_d = 1'b1;
          end
        end
        ADVANCE: begin
          tmr_load_c    = 1'b1;
          done_seen_d   = 1'b0;
          frame_start_d = 1'b1;
          state_d       = ret_pause_q ? PAUSED : SHOW;
          if (anim_switch_c) begin
            anim_sel_d  = anim_req;
            frame_idx_d = '0;
            dir_d       = 1'b0;
          end else begin
            case (mode_c)
              ONCE: begin
                if (last_c) begin
                  state_d       = IDLE;
                  frame_start_d = 1'b0;
                  frame_stop_d  = 1'b1;
                  seq_done_d    = 1'b1;
                end else begin
                  frame_idx_d = frame_idx_q + FRAME_W'(1);
                end
              end
              // Endpoints shown once: direction flips while stepping away from them
              PINGPONG: begin
                if (!dir_q) begin
                  if (last_c) begin
                    dir_d       = 1'b1;
                    frame_idx_d = first_c ? '0 : frame_idx_q - FRAME_W'(1);
                  end else begin
                    frame_idx_d = frame_idx_q + FRAME_W'(1);
                  end
                end else begin
                  if (first_c) begin
                    dir_d       = 1'b0;
                    frame_idx_d = last_c ? '0 : frame_idx_q + FRAME_W'(1);
                  end else begin
                    frame_idx_d = frame_idx_q - FRAME_W'(1);
                  end
                end
              end
              default: begin
                if (last_c) begin
                  frame_idx_d = '0;
`ifdef LED_SEQ_AUTOCYCLE_EN
                  anim_sel_d  = (anim_sel_q == ANIM_W'(NUM_ANIM - 1)) ? '0
                                                                      : anim_sel_q + ANIM_W'(1);
`endif
                end else begin
                  frame_idx_d = frame_idx_q + FRAME_W'(1);
                end
              end
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ret_pause_q   <= 1'b0;
      anim_sel_q    <= '0;
      frame_idx_q   <= '0;
      dir_q         <= 1'b0;
      done_seen_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_stop_q  <= 1'b0;
      seq_done_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_pause_q   <= ret_pause_d;
      anim_sel_q    <= anim_sel_d;
      frame_idx_q   <= frame_idx_d;
      dir_q         <= dir_d;
      done_seen_q   <= done_seen_d;
      frame_start_q <= frame_start_d;
      frame_stop_q  <= frame_stop_d;
      seq_done_q    <= seq_done_d;
      busy_q        <= (state_d != IDLE);
    end
  end

  assign frame_start = frame_start_q;
  assign frame_stop  = frame_stop_q;
  assign anim_sel    = anim_sel_q;
  assign frame_idx   = frame_idx_q;
  assign busy        = busy_q;
  assign seq_done    = seq_done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_led_cube_anim_sequencer.sv
// Directed bench for led_cube_anim_sequencer with FRAMES=4, FRAME_TICKS=8.
module tb_led_cube_anim_sequencer;

  localparam int unsigned NUM_ANIM    = 5;
  localparam int unsigned FRAMES      = 4;
  localparam int unsigned FRAME_TICKS = 8;
  localparam int unsigned TICK_W      = 21;
  localparam int unsigned ANIM_W      = 3;
  localparam int unsigned FRAME_W     = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               pause = 1'b0;
  logic               step = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic [ANIM_W-1:0]  anim_req = '0;
  logic [TICK_W-1:0]  speed_ticks = '0;
  logic               frame_done = 1'b0;
  logic               frame_start;
  logic               frame_stop;
  logic [ANIM_W-1:0]  anim_sel;
  logic [FRAME_W-1:0] frame_idx;
  logic               busy;
  logic               seq_done;
  logic [2:0]         state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_period = 3;
  int fs_idx[$];
  int fs_cyc[$];
  int stop_cnt = 0;
  int sdone_cnt = 0;

  led_cube_anim_sequencer #(
    .NUM_ANIM   (NUM_ANIM),
    .FRAMES     (FRAMES),
    .FRAME_TICKS(FRAME_TICKS),
    .TICK_W     (TICK_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .step       (step),
    .mode       (mode),
    .anim_req   (anim_req),
    .speed_ticks(speed_ticks),
    .frame_done (frame_done),
    .frame_start(frame_start),
    .frame_stop (frame_stop),
    .anim_sel   (anim_sel),
    .frame_idx  (frame_idx),
    .busy       (busy),
    .seq_done   (seq_done),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every frame_start with its frame index and cycle; count stop/done pulses
  always @(negedge clk) begin
    if (frame_start) begin
      fs_idx.push_back(int'(frame_idx));
      fs_cyc.push_back(cyc);
    end
    if (frame_stop) stop_cnt++;
    if (seq_done)   sdone_cnt++;
  end

  // Frame-driver stand-in: one frame_done pulse every done_period cycles
  initial begin : done_gen
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (done_period != 0 && cnt >= done_period - 1) begin
        frame_done = 1'b1;
        cnt = 0;
      end else begin
        frame_done = 1'b0;
        cnt++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(2);
  endtask

  task automatic wait_fs(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (fs_idx.size() < target && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(fs_idx.size()), 32'(target));
  endtask

  initial begin : main
    int base, s0, d0, k;
    int exp_loop[6] = '{0, 1, 2, 3, 0, 1};
    int exp_pp[8]   = '{0, 1, 2, 3, 2, 1, 0, 1};

    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_frame_idx", 32'(frame_idx), 32'd0);
    check("rst_anim_sel", 32'(anim_sel), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // LOOP: 0,1,2,3,0,1 with 9-cycle spacing
    mode = 2'd0;
    base = fs_idx.size();
    go();
    wait_fs(base + 6, 200, "loop_wait");
    for (int i = 0; i < 6; i++) check($sformatf("loop_idx%0d", i), 32'(fs_idx[base+i]), 32'(exp_loop[i]));
    for (int i = 1; i < 6; i++) check($sformatf("loop_gap%0d", i), 32'(fs_cyc[base+i] - fs_cyc[base+i-1]), 32'd9);
    check("loop_busy", 32'(busy), 32'd1);
    s0 = stop_cnt;
    halt();
    check("loop_stop_pulse", 32'(stop_cnt - s0), 32'd1);
    check("loop_stop_state", 32'(state_dbg), 32'd0);
    check("loop_stop_idx", 32'(frame_idx), 32'd0);

    // ONCE: frames 0..3 then seq_done + frame_stop, idle holding frame 3
    mode = 2'd1;
    base = fs_idx.size();
    s0 = stop_cnt;
    d0 = sdone_cnt;
    go();
    k = 0;
    while (busy && k < 200) begin
      tick(1);
      k++;
    end
    tick(2);
    check("once_starts", 32'(fs_idx.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("once_idx%0d", i), 32'(fs_idx[base+i]), 32'(i));
    check("once_seq_done", 32'(sdone_cnt - d0), 32'd1);
    check("once_frame_stop", 32'(stop_cnt - s0), 32'd1);
    check("once_idx_hold", 32'(frame_idx), 32'd3);
    check("once_state", 32'(state_dbg), 32'd0);
    check("once_busy", 32'(busy), 32'd0);

    // PINGPONG: 0,1,2,3,2,1,0,1
    mode = 2'd2;
    base = fs_idx.size();
    go();
    wait_fs(base + 8, 200, "pp_wait");
    for (int i = 0; i < 8; i++) check($sformatf("pp_idx%0d", i), 32'(fs_idx[base+i]), 32'(exp_pp[i]));
    halt();

    // Short period gated by slow frame_done: advance every 10 cycles
    mode = 2'd0;
    speed_ticks = TICK_W'(2);
    done_period = 10;
    base = fs_idx.size();
    go();
    wait_fs(base + 5, 200, "slow_wait");
    for (int i = 2; i < 5; i++) check($sformatf("slow_gap%0d", i), 32'(fs_cyc[base+i] - fs_cyc[base+i-1]), 32'd10);
    halt();
    speed_ticks = '0;
    done_period = 3;

    // Pause at frame 1, single-step, resume
    base = fs_idx.size();
    go();
    wait_fs(base + 2, 100, "pause_wait");
    pause = 1'b1;
    tick(1);
    s0 = fs_idx.size();
    tick(50);
    check("pause_idx", 32'(frame_idx), 32'd1);
    check("pause_no_start", 32'(fs_idx.size() - s0), 32'd0);
    check("pause_state", 32'(state_dbg), 32'd3);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(3);
    check("step_idx", 32'(frame_idx), 32'd2);
    check("step_one_start", 32'(fs_idx.size() - s0), 32'd1);
    check("step_state", 32'(state_dbg), 32'd3);
    pause = 1'b0;
    wait_fs(s0 + 2, 50, "resume_wait");
    check("resume_idx", 32'(fs_idx[s0+1]), 32'd3);
    check("resume_state", 32'(state_dbg), 32'd2);
    halt();

    // Animation switch at the next frame boundary, then stop mid-SHOW
    anim_req = '0;
    base = fs_idx.size();
    go();
    wait_fs(base + 3, 100, "sw_wait");
    check("sw_before_anim", 32'(anim_sel), 32'd0);
    check("sw_before_idx", 32'(frame_idx), 32'd2);
    anim_req = ANIM_W'(3);
    wait_fs(base + 4, 50, "sw_wait2");
    check("sw_anim", 32'(anim_sel), 32'd3);
    check("sw_idx", 32'(frame_idx), 32'd0);
    check("sw_logged_idx", 32'(fs_idx[base+3]), 32'd0);
    tick(2);
    s0 = stop_cnt;
    halt();
    check("show_stop_pulse", 32'(stop_cnt - s0), 32'd1);
    check("show_stop_state", 32'(state_dbg), 32'd0);
    anim_req = '0;

    // stop together with start from IDLE: stays idle, no pulse
    s0 = stop_cnt;
    stop = 1'b1;
    start = 1'b1;
    tick(3);
    start = 1'b0;
    stop = 1'b0;
    tick(1);
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_state", 32'(state_dbg), 32'd0);
    check("ss_no_stop", 32'(stop_cnt - s0), 32'd0);

    // Reset mid-frame: immediate IDLE without frame_stop
    go();
    tick(5);
    s0 = stop_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_state", 32'(state_dbg), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    tick(2);
    check("rstmid_no_stop", 32'(stop_cnt - s0), 32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_cube_anim_sequencer.md
Name: led_cube_anim_sequencer

Overview:
Parametrised animation sequencer for the 8x8x8 LED cube.
- Selects one of NUM_ANIM stored animations and steps a frame index through FRAMES frames at a runtime-programmable frame period.
- Hands each frame to the single-frame layer/latch driver through a start/stop/done handshake.
- Adds loop, one-shot and ping-pong modes, plus pause, single-step and glitch-free animation switching at frame boundaries.
- Top level forms the pattern-memory address as {anim_sel, frame_idx, driver byte address}.

Parameters:
- NUM_ANIM, 5: number of stored animations.
- FRAMES, 150: frames per animation.
- FRAME_TICKS, 1500000: default frame period in clk cycles (30 ms at 50 MHz).
- TICK_W, 21: width of the frame timer and speed_ticks.
- ANIM_W, $clog2(NUM_ANIM): derived, not overridden.
- FRAME_W, $clog2(FRAMES): derived, not overridden.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; begin playback from IDLE.
- stop  in  1  level; abort to IDLE; highest priority.
- pause  in  1  level; freeze frame timer while high.
- step  in  1  one-cycle pulse; advance one frame while PAUSED.
- mode  in  2  0 LOOP, 1 ONCE, 2 PINGPONG, 3 treated as LOOP.
- anim_req  in  ANIM_W  requested animation.
- speed_ticks  in  TICK_W  frame period; 0 selects FRAME_TICKS.
- frame_done  in  1  pulse from frame driver: one full 8-layer refresh done.
- frame_start  out  1  one-cycle pulse to frame driver.
- frame_stop  out  1  one-cycle pulse to frame driver.
- anim_sel  out  ANIM_W  active animation.
- frame_idx  out  FRAME_W  active frame.
- busy  out  1  high in any state except IDLE.
- seq_done  out  1  one-cycle pulse at end of a ONCE pass.
- state_dbg  out  3  encoded state for the LEDR debug view.

Behaviour:
- Reset values (async, rst_n low):
  - state=IDLE; anim_sel=0, frame_idx=0, dir=forward, timer=0, done_seen=0.
  - All pulse outputs 0; busy=0.
- States:
  - IDLE: start and !stop -> LOAD.
  - LOAD: sample anim_req into anim_sel, frame_idx=0, dir=forward -> SHOW. Register frame_start=1 for the cycle entering SHOW.
  - SHOW: timer counts 0..P-1, where P = speed_ticks, or FRAME_TICKS if speed_ticks is 0. P is sampled at each SHOW entry.
    - At P-1 the timer saturates.
    - Exit to ADVANCE only when the timer has saturated and done_seen=1. Every frame is therefore refreshed at least once even if P is shorter than one refresh.
    - pause=1 -> PAUSED.
  - PAUSED: timer and frame_idx frozen; the driver keeps refreshing the current frame.
    - pause=0 -> SHOW, resuming the timer with no frame_start.
    - step pulse -> ADVANCE with return target PAUSED.
  - ADVANCE (1 cycle): compute next frame, clear timer and done_seen, pulse frame_start next cycle.
    - Go to SHOW, or to PAUSED if entered via step.
- done_seen: set by frame_done in SHOW/PAUSED; cleared in LOAD and ADVANCE.
- Next-frame rules, applied in ADVANCE:
  - Animation switch: if anim_req != anim_sel, set anim_sel=anim_req, frame_idx=0, dir=forward. This takes priority over the mode rules.
  - LOOP: FRAMES-1 -> 0.
  - ONCE: at FRAMES-1, pulse seq_done, pulse frame_stop -> IDLE; frame_idx holds FRAMES-1.
  - PINGPONG: reverse dir at FRAMES-1 and at 0; endpoints are shown once (...,148,149,148,...,1,0,1,...).
  - FRAMES=1: frame_idx stays 0 in every mode; ONCE ends after the first frame.
- stop: from any non-IDLE state -> IDLE next cycle, pulse frame_stop, frame_idx=0.
  - stop and start together: stop wins.
  - stop while IDLE: no pulse.
- Mode changes take effect at the next ADVANCE.
- step outside PAUSED is ignored.
- pause and step in the same cycle while in SHOW: the pause transition only.
- Reset mid-frame: immediate IDLE; no frame_stop pulse (the driver is reset by the same rst_n).

Optional Feature:
LED_SEQ_AUTOCYCLE_EN
- Defined: in LOOP mode, wrapping FRAMES-1 -> 0 also advances anim_sel to (anim_sel+1) mod NUM_ANIM, and anim_req is ignored after LOAD.
- Undefined: anim_sel changes only via anim_req as described above.

Decomposition:
- Package led_cube_pkg holds:
  - seq_state_e: IDLE, LOAD, SHOW, PAUSED, ADVANCE.
  - seq_mode_e: LOOP, ONCE, PINGPONG.
  - Constants: CUBE_DIM=8 and FRAME_BYTES=64.
- Natural sub-module: led_cube_frame_timer, a saturating TICK_W counter with clear, enable, period load and an expired flag.

Test Plan (FRAMES=4, FRAME_TICKS=8, frame_done pulsed every 3 cycles):
- LOOP, start -> frame_idx 0,1,2,3,0,1; frame_start pulses spaced 9 cycles apart (8 SHOW + 1 ADVANCE); busy=1 throughout.
- ONCE -> frames 0..3; then seq_done and frame_stop each pulse once; state IDLE; frame_idx=3; busy=0.
- PINGPONG -> sequence 0,1,2,3,2,1,0,1.
- speed_ticks=2 with frame_done only every 10 cycles -> frames advance every 10 cycles (gated by done_seen), not every 2.
- pause at frame 1 for 50 cycles -> frame_idx stays 1 and there is no frame_start; then step -> frame_idx=2 with one frame_start, still PAUSED; pause=0 -> resumes.
- anim_req 0->3 at frame 2 -> at the next ADVANCE anim_sel=3, frame_idx=0.
- stop asserted together with start, and stop mid-SHOW -> IDLE; frame_stop pulses only in the mid-SHOW case.
